teng_rx_block_sync: RTL and testbench
=====================================

Name: teng_rx_block_sync

Overview:
- Receive-side PCS front end of teng_mac; the counterpart of the TX 66b->32b gearbox.
- Converts the 32-bit per-cycle GT receive word stream into 66-bit blocks (2-bit sync header plus 64-bit payload).
- Runs a clause-49-style block-lock state machine and requests bit slips until header alignment is found.
- Its lock output drives link_up, which feeds data_valid_i of teng_phy.

Parameters:
- P_LOCK_CNT, 64: consecutive valid headers required to declare lock.
- P_WINDOW, 64: block window size used for bad-header counting while locked.
- P_BAD_LIMIT, 16: bad headers within one window that force loss of lock.

Ports:
- rx_user_clk_i  in  1  GT receive user clock; the only clock.
- rx_user_rst_i  in  1  synchronous, active-high reset.
- rx_data_i  in  32  GT receive word; bit 0 is the first bit on the wire.
- rx_data_valid_i  in  1  word qualifier; when low, the word is ignored and all state holds.
- blk_header_o  out  2  sync header; bit 0 is the first received bit.
- blk_data_o  out  64  block payload; bit 0 is the first received payload bit.
- blk_valid_o  out  1  one-cycle strobe, one per emitted block.
- blk_lock_o  out  1  block lock indication.
- slip_o  out  1  one-cycle pulse for each slip performed.
- bad_hdr_o  out  1  one-cycle pulse, coincident with blk_valid_o, when the header is 00 or 11.

Behaviour:
- Reset: all outputs 0, fill count 0, buffer cleared, FSM in HUNT with all counters 0, slip_pend 0. Reset asserted mid-operation discards partial blocks and drops lock in the next cycle.
- Gearbox:
  - 98-bit accumulator with fill count c in 0..65 between cycles.
  - On each valid word: buf |= word << c, then c += 32. If slip_pend is set, the word is first shifted right by 1, only 31 bits are added, and slip_pend clears.
  - If the resulting c >= 66: emit buf[65:0], shift buf right by 66, c -= 66.
  - At most one block per cycle. Exactly 16 blocks per 33 valid words when no slip occurs.
  - Latency: the block appears on the registered outputs one cycle after the word that completes it.
  - Outputs are registered; blk_data_o and blk_header_o hold their value between strobes.
- Header test: valid = header[0] XOR header[1] (01 or 10).
- Lock FSM, evaluated once per emitted block:
  - HUNT: valid header increments sh_cnt; at sh_cnt == P_LOCK_CNT go to LOCKED with blk_lock_o = 1. An invalid header sets slip_pend, pulses slip_o, clears sh_cnt and goes to SLIP_WAIT.
  - SLIP_WAIT: the first block emitted after the slip is applied is discarded from header testing, then go to HUNT. blk_valid_o still strobes for it.
  - LOCKED:
    - Each block increments win_cnt; invalid headers increment bad_cnt.
    - If bad_cnt reaches P_BAD_LIMIT: blk_lock_o = 0 on the same registered edge as the block strobe, slip_pend is set, slip_o pulses, all counters clear, and the FSM goes to SLIP_WAIT.
    - Otherwise, at win_cnt == P_WINDOW both counters clear.
    - If the 16th bad header lands on the 64th block, loss of lock takes priority over window clear.
- Slip requests cannot stack: slip_pend is only set from HUNT or LOCKED, never from SLIP_WAIT.
- No slip occurs while rx_data_valid_i is low; slip_pend is held until the next valid word.
- Counters saturate and do not wrap: sh_cnt is 7 bits, win_cnt 7 bits, bad_cnt 5 bits.

Decomposition:
- Package teng_pcs_pkg holds:
  - sync header constants (SH_DATA = 2'b01, SH_CTRL = 2'b10);
  - FSM state encoding (HUNT, SLIP_WAIT, LOCKED);
  - default lock and window constants.
- Sub-module teng_rx_gearbox (32->66 with slip input) is instantiated by teng_rx_block_sync, which adds the lock FSM.

Test Plan:
- Aligned stream of 66-bit blocks with valid headers, rx_data_valid_i always 1 -> exactly 16 blk_valid_o per 33 words; blk_lock_o rises on the strobe of block 64; slip_o never pulses.
- Same stream offset by 17 bits, payload chosen so no other offset gives valid headers -> exactly 17 slip_o pulses; lock within (17 × 2 + 64) blocks; payloads then match the source.
- While locked, inject 15 bad headers in one 64-block window -> blk_lock_o stays 1; inject 16 -> blk_lock_o falls with the 16th bad_hdr_o, slip_o pulses once.
- 16th bad header placed on the 64th block of a window -> lock lost; the window clear does not save it.
- rx_data_valid_i toggled 1/0 every cycle -> same block contents and lock timing measured in valid words; no state advance on idle cycles.
- Assert rx_user_rst_i for 1 cycle while locked mid-block -> all outputs 0 next cycle; re-lock after 64 aligned blocks, with the first post-reset block starting at the first post-reset word.

Source files
------------

// File: rtl/teng_pcs_pkg.sv
// Shared definitions for the teng_mac receive PCS front end.
// Holds the 66b sync header codes, the block-lock state encoding, the
// default lock/window thresholds and small helpers used by the gearbox and
// the block-lock state machine.
package teng_pcs_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int WORD_W = 32;
  localparam int BLK_W  = 66;
  localparam int ACC_W  = 98;

  localparam int DEF_LOCK_CNT  = 64;
  localparam int DEF_WINDOW    = 64;
  localparam int DEF_BAD_LIMIT = 16;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } lock_state_e;

  // A header is usable only when its two bits differ (01 or 10).
  function automatic logic hdr_ok(input logic [1:0] hdr);
    return hdr[0] ^ hdr[1];
  endfunction

  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (&v) ? v : v + 7'd1;
  endfunction

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (&v) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/teng_rx_block_sync_if.sv
// Receive word / block bus between the GT side and teng_rx_block_sync.
//   rx_data_i       : 32-bit GT word, bit 0 first on the wire
//   rx_data_valid_i : word qualifier
//   blk_header_o    : 2-bit sync header, bit 0 first received
//   blk_data_o      : 64-bit payload, bit 0 first received
//   blk_valid_o     : one strobe per emitted block
//   blk_lock_o      : block lock indication
//   slip_o          : one pulse per slip performed
//   bad_hdr_o       : pulse with blk_valid_o when the header is 00 or 11
// master = word source / block consumer, slave = block sync.
interface teng_rx_block_sync_if;
  logic [31:0] rx_data_i;
  logic        rx_data_valid_i;
  logic [1:0]  blk_header_o;
  logic [63:0] blk_data_o;
  logic        blk_valid_o;
  logic        blk_lock_o;
  logic        slip_o;
  logic        bad_hdr_o;

  modport master (
    output rx_data_i, rx_data_valid_i,
    input  blk_header_o, blk_data_o, blk_valid_o, blk_lock_o, slip_o, bad_hdr_o
  );

  modport slave (
    input  rx_data_i, rx_data_valid_i,
    output blk_header_o, blk_data_o, blk_valid_o, blk_lock_o, slip_o, bad_hdr_o
  );
endinterface

// File: rtl/teng_rx_gearbox.sv
// 32b -> 66b receive gearbox with single-bit slip.
// Accumulates words LSB-first into a 98-bit buffer and presents a completed
// 66-bit block combinationally in the cycle of the word that completes it;
// the caller registers it. A slip drops the first bit of the next valid word.
//   clk, rst  : clock, synchronous active-high reset
//   data      : incoming 32-bit word, bit 0 first
//   valid     : word qualifier; when low all state holds
//   slip_set  : request one slip on the next valid word
//   blk       : block candidate, bits [1:0] header, [65:2] payload
//   blk_valid : blk is complete this cycle
module teng_rx_gearbox
  import teng_pcs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data,
  input  logic              valid,
  input  logic              slip_set,
  output logic [BLK_W-1:0]  blk,
  output logic              blk_valid
);

  logic [ACC_W-1:0]  acc_q;
  logic [6:0]        fill_q;
  logic              slip_pend_q;

  logic [WORD_W-1:0] word_eff;
  logic [6:0]        fill_sum;
  logic [ACC_W-1:0]  acc_sum;

  // NOTE: every signal here is assigned on every path through the block, so
  // no latch can be inferred.
  always_comb begin
    word_eff  = slip_pend_q ? {1'b0, data[WORD_W-1:1]} : data;
    fill_sum  = fill_q + (slip_pend_q ? 7'd31 : 7'd32);
    acc_sum   = acc_q | ({66'd0, word_eff} << fill_q);
    blk_valid = valid && (fill_sum >= 7'd66);
    blk       = acc_sum[BLK_W-1:0];
  end

  // NOTE: registers use <= so every one of them samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the accumulator must be cleared on reset: words are OR-ed in
      // above fill_q, so leftover bits would corrupt the first block.
      acc_q       <= '0;
      fill_q      <= '0;
      slip_pend_q <= 1'b0;
    end else begin
      if (valid) begin
        acc_q  <= blk_valid ? (acc_sum >> BLK_W) : acc_sum;
        fill_q <= blk_valid ? (fill_sum - 7'd66) : fill_sum;
      end
      // A slip request always arrives on a block-emitting word, and the word
      // after an emit can never emit, so set and consume never collide.
      if (slip_set) begin
        slip_pend_q <= 1'b1;
      end else if (valid) begin
        slip_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/teng_rx_block_sync.sv
// Receive PCS front end: 32b GT words -> 66b blocks plus block-lock FSM.
// The FSM hunts for 64 consecutive valid headers, slipping one bit after
// each bad header, and while locked drops lock after 16 bad headers inside
// a 64-block window. blk_lock_o feeds link_up.
//   rx_user_clk_i : GT receive user clock
//   rx_user_rst_i : synchronous active-high reset
//   bus           : word input and block / lock / slip outputs
module teng_rx_block_sync
  import teng_pcs_pkg::*;
#(
  parameter int P_LOCK_CNT  = DEF_LOCK_CNT,
  parameter int P_WINDOW    = DEF_WINDOW,
  parameter int P_BAD_LIMIT = DEF_BAD_LIMIT
) (
  input logic                  rx_user_clk_i,
  input logic                  rx_user_rst_i,
  teng_rx_block_sync_if.slave  bus
);

  localparam logic [6:0] LOCK_CNT  = 7'(P_LOCK_CNT);
  localparam logic [6:0] WINDOW    = 7'(P_WINDOW);
  localparam logic [4:0] BAD_LIMIT = 5'(P_BAD_LIMIT);

  logic [BLK_W-1:0] gb_blk;
  logic             gb_valid;
  logic             slip_set;

  lock_state_e state_q;
  logic [6:0]  sh_cnt_q;
  logic [6:0]  win_cnt_q;
  logic [4:0]  bad_cnt_q;

  logic        hdr_good;
  logic [6:0]  sh_nxt;
  logic [6:0]  win_nxt;
  logic [4:0]  bad_nxt;
  logic        hunt_fail;
  logic        lose_lock;

  teng_rx_gearbox u_gearbox (
    .clk       (rx_user_clk_i),
    .rst       (rx_user_rst_i),
    .data      (bus.rx_data_i),
    .valid     (bus.rx_data_valid_i),
    .slip_set  (slip_set),
    .blk       (gb_blk),
    .blk_valid (gb_valid)
  );

  always_comb begin
    hdr_good  = hdr_ok(gb_blk[1:0]);
    sh_nxt    = sat_inc7(sh_cnt_q);
    win_nxt   = sat_inc7(win_cnt_q);
    bad_nxt   = hdr_good ? bad_cnt_q : sat_inc5(bad_cnt_q);
    hunt_fail = gb_valid && (state_q == HUNT) && !hdr_good;
    // Loss of lock is tested before the window clear, so a limit-reaching
    // bad header on the last block of a window still drops lock.
    lose_lock = gb_valid && (state_q == LOCKED) && (bad_nxt == BAD_LIMIT);
    // SLIP_WAIT never requests a slip, so requests cannot stack.
    slip_set  = hunt_fail || lose_lock;
  end

  always_ff @(posedge rx_user_clk_i) begin
    if (rx_user_rst_i) begin
      state_q          <= HUNT;
      sh_cnt_q         <= '0;
      win_cnt_q        <= '0;
      bad_cnt_q        <= '0;
      bus.blk_header_o <= '0;
      bus.blk_data_o   <= '0;
      bus.blk_valid_o  <= 1'b0;
      bus.blk_lock_o   <= 1'b0;
      bus.slip_o       <= 1'b0;
      bus.bad_hdr_o    <= 1'b0;
    end else begin
      bus.blk_valid_o <= gb_valid;
      bus.slip_o      <= slip_set;
      bus.bad_hdr_o   <= gb_valid && !hdr_good;
      if (gb_valid) begin
        bus.blk_header_o <= gb_blk[1:0];
        bus.blk_data_o   <= gb_blk[BLK_W-1:2];
        unique case (state_q)
          HUNT: begin
            if (!hdr_good) begin
              sh_cnt_q <= '0;
              state_q  <= SLIP_WAIT;
            end else if (sh_nxt == LOCK_CNT) begin
              sh_cnt_q       <= '0;
              state_q        <= LOCKED;
              bus.blk_lock_o <= 1'b1;
            end else begin
              sh_cnt_q <= sh_nxt;
            end
          end
          // This block straddles the slip point, so its header is ignored.
          SLIP_WAIT: state_q <= HUNT;
          LOCKED: begin
            if (lose_lock) begin
              bus.blk_lock_o <= 1'b0;
              win_cnt_q      <= '0;
              bad_cnt_q      <= '0;
              state_q        <= SLIP_WAIT;
            end else if (win_nxt == WINDOW) begin
              win_cnt_q <= '0;
              bad_cnt_q <= '0;
            end else begin
              win_cnt_q <= win_nxt;
              bad_cnt_q <= bad_nxt;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_teng_rx_block_sync.sv
// Self-checking bench for teng_rx_block_sync: a bit-queue model of the
// receive stream and a counter-level model of the lock rules run alongside
// the DUT; one process compares every output every cycle, and literal
// expectations pin block counts, lock timing and slip counts.
module tb_teng_rx_block_sync;
  import teng_pcs_pkg::*;

  localparam int LOCK_N = 64;
  localparam int WIN_N  = 64;
  localparam int BAD_N  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  teng_rx_block_sync_if bus ();

  teng_rx_block_sync dut (
    .rx_user_clk_i (clk),
    .rx_user_rst_i (rst),
    .bus           (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- source stream ----------------
  bit          tx_q[$];
  logic [63:0] src_pay[$];

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic push_block(input logic [1:0] h, input logic [63:0] p);
    for (int i = 0; i < 2; i++) tx_q.push_back(h[i]);
    for (int i = 0; i < 64; i++) tx_q.push_back(p[i]);
    src_pay.push_back(p);
  endtask

  task automatic push_good(input int n);
    for (int i = 0; i < n; i++) push_block(($urandom_range(0, 1) != 0) ? SH_DATA : SH_CTRL, rand64());
  endtask

  task automatic push_bad();
    push_block(($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11, rand64());
  endtask

  // ---------------- reference model ----------------
  bit          m_q[$];
  bit          m_slip_pend, m_locked, m_skip;
  int          m_good, m_win, m_bad, m_blocks;
  logic [1:0]  e_hdr  = '0;
  logic [63:0] e_data = '0;
  logic        e_valid = 1'b0, e_lock = 1'b0, e_slip = 1'b0, e_bad = 1'b0;

  task automatic m_request_slip();
    m_slip_pend = 1'b1;
    e_slip      = 1'b1;
    m_skip      = 1'b1;
  endtask

  task automatic model_step(input logic [31:0] w, input logic v, input logic r);
    logic [65:0] b;
    bit          good;
    e_valid = 1'b0;
    e_slip  = 1'b0;
    e_bad   = 1'b0;
    if (r === 1'b1) begin
      m_q.delete();
      m_slip_pend = 0; m_locked = 0; m_skip = 0;
      m_good = 0; m_win = 0; m_bad = 0; m_blocks = 0;
      e_hdr = '0; e_data = '0; e_lock = 1'b0;
      return;
    end
    if (v !== 1'b1) return;
    for (int i = 0; i < 32; i++)
      if (!(m_slip_pend && i == 0)) m_q.push_back(w[i]);
    m_slip_pend = 0;
    if (m_q.size() >= 66) begin
      for (int i = 0; i < 66; i++) b[i] = m_q.pop_front();
      m_blocks++;
      e_valid = 1'b1;
      e_hdr   = b[1:0];
      e_data  = b[65:2];
      good    = (b[0] != b[1]);
      e_bad   = !good;
      if (m_skip) begin
        m_skip = 0;
      end else if (!m_locked) begin
        if (good) begin
          m_good++;
          if (m_good == LOCK_N) begin
            m_locked = 1;
            m_good   = 0;
          end
        end else begin
          m_good = 0;
          m_request_slip();
        end
      end else begin
        m_win++;
        if (!good) m_bad++;
        if (m_bad == BAD_N) begin
          m_locked = 0; m_win = 0; m_bad = 0;
          m_request_slip();
        end else if (m_win == WIN_N) begin
          m_win = 0; m_bad = 0;
        end
      end
    end
    e_lock = m_locked;
  endtask

  always @(posedge clk) model_step(bus.rx_data_i, bus.rx_data_valid_i, rst);

  // ---------------- compare + observation ----------------
  bit          cmp_en = 0;
  int          words_sent = 0;
  int          dut_blocks, dut_slips, lock_rise_block, lock_fall_block;
  int          slips_at_fall, words_at_lock, snap_idx;
  logic [63:0] snap_data;
  logic [1:0]  snap_hdr;
  logic        snap_lock;
  logic        prev_lock;

  task automatic reset_stats();
    dut_blocks = 0; dut_slips = 0; lock_rise_block = 0; lock_fall_block = 0;
    slips_at_fall = 0; words_at_lock = 0; words_sent = 0; snap_idx = -1;
    snap_data = '0; snap_hdr = '0; snap_lock = 1'b0; prev_lock = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("blk_valid", bus.blk_valid_o, e_valid);
      check("blk_lock", bus.blk_lock_o, e_lock);
      check("slip", bus.slip_o, e_slip);
      check("bad_hdr", bus.bad_hdr_o, e_bad);
      check("blk_header", bus.blk_header_o, e_hdr);
      check("blk_data", bus.blk_data_o, e_data);
      if (bus.blk_valid_o === 1'b1) dut_blocks++;
      if (bus.slip_o === 1'b1) dut_slips++;
      if (bus.blk_valid_o === 1'b1 && dut_blocks == snap_idx) begin
        snap_data = bus.blk_data_o;
        snap_hdr  = bus.blk_header_o;
        snap_lock = bus.blk_lock_o;
      end
      if (bus.blk_lock_o === 1'b1 && prev_lock === 1'b0 && lock_rise_block == 0) begin
        lock_rise_block = dut_blocks;
        words_at_lock   = words_sent;
      end
      if (bus.blk_lock_o === 1'b0 && prev_lock === 1'b1 && lock_fall_block == 0) begin
        lock_fall_block = dut_blocks;
        slips_at_fall   = dut_slips;
      end
      prev_lock = bus.blk_lock_o;
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit v, input bit r);
    logic [31:0] w;
    @(negedge clk);
    w = $urandom;
    if (v && !r) begin
      for (int i = 0; i < 32; i++) begin
        if (tx_q.size() > 0) w[i] = tx_q.pop_front();
        else w[i] = 1'($urandom_range(0, 1));
      end
    end
    bus.rx_data_i       = w;
    bus.rx_data_valid_i = v;
    rst                 = r;
    @(posedge clk);
    if (v && !r) words_sent++;
  endtask

  task automatic run_words(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0);
      if (toggle) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    tx_q.delete();
    src_pay.delete();
    reset_stats();
  endtask

  int r_off;

  initial begin
    bus.rx_data_i       = '0;
    bus.rx_data_valid_i = 1'b0;
    reset_stats();
    do_reset();

    // Reset state.
    check("rst blk_valid", bus.blk_valid_o, 1'b0);
    check("rst blk_lock", bus.blk_lock_o, 1'b0);
    check("rst slip", bus.slip_o, 1'b0);
    check("rst bad_hdr", bus.bad_hdr_o, 1'b0);
    check("rst blk_header", bus.blk_header_o, 2'b00);
    check("rst blk_data", bus.blk_data_o, 64'd0);
    cmp_en = 1;

    // Aligned stream: 16 blocks per 33 words, lock on block 64 (word 132).
    push_good(80);
    run_words(33, 1'b0);
    check("aligned blocks per 33 words", dut_blocks, 16);
    run_words(107, 1'b0);
    check("aligned lock block", lock_rise_block, 64);
    check("aligned lock word", words_at_lock, 132);
    check("aligned slips", dut_slips, 0);

    // 17-bit offset; payload bits 47..63 zero so only offset 0 is valid.
    do_reset();
    for (int i = 0; i < 17; i++) tx_q.push_back(1'b0);
    for (int i = 0; i < 200; i++) push_block(SH_CTRL, rand64() & 64'h0000_7FFF_FFFF_FFFF);
    snap_idx = 98;
    run_words(240, 1'b0);
    check("offset17 slips", dut_slips, 17);
    check("offset17 lock block", lock_rise_block, 98);
    check("offset17 payload", snap_data, src_pay[97]);
    check("offset17 header", snap_hdr, SH_CTRL);

    // 15 bad in one window keeps lock; 16 in the next window drops it.
    do_reset();
    push_good(64);
    r_off = $urandom_range(0, 3);
    for (int p = 0; p < 64; p++)
      if (p % 4 == r_off && p / 4 < 15) push_bad(); else push_good(1);
    r_off = $urandom_range(0, 2);
    for (int p = 0; p < 64; p++)
      if (p % 3 == r_off && p / 3 < 16) push_bad(); else push_good(1);
    snap_idx = 128;
    run_words(420, 1'b0);
    check("15 bad keeps lock", snap_lock, 1'b1);
    check("16 bad lock loss block", lock_fall_block, 128 + 45 + r_off + 1);
    check("16 bad single slip", slips_at_fall, 1);

    // 16th bad header on the 64th block of a window.
    do_reset();
    push_good(64);
    r_off = $urandom_range(0, 2);
    for (int p = 0; p < 64; p++)
      if ((p % 4 == r_off && p / 4 < 15) || p == 63) push_bad(); else push_good(1);
    push_good(4);
    run_words(280, 1'b0);
    check("window-edge lock loss block", lock_fall_block, 128);
    check("window-edge single slip", slips_at_fall, 1);

    // Valid toggling every cycle: timing in valid words is unchanged.
    do_reset();
    push_good(80);
    run_words(33, 1'b1);
    check("toggle blocks per 33 words", dut_blocks, 16);
    run_words(107, 1'b1);
    check("toggle lock block", lock_rise_block, 64);
    check("toggle lock word", words_at_lock, 132);
    check("toggle slips", dut_slips, 0);

    // One-cycle reset while locked, mid-block, then re-lock from scratch.
    do_reset();
    push_good(80);
    run_words(140, 1'b0);
    check("pre-reset lock", bus.blk_lock_o, 1'b1);
    step(1'b1, 1'b1);
    #1;
    check("mid rst blk_valid", bus.blk_valid_o, 1'b0);
    check("mid rst blk_lock", bus.blk_lock_o, 1'b0);
    check("mid rst slip", bus.slip_o, 1'b0);
    check("mid rst bad_hdr", bus.bad_hdr_o, 1'b0);
    check("mid rst blk_header", bus.blk_header_o, 2'b00);
    check("mid rst blk_data", bus.blk_data_o, 64'd0);
    tx_q.delete();
    src_pay.delete();
    reset_stats();
    push_good(80);
    snap_idx = 1;
    run_words(140, 1'b0);
    check("post-reset first block", snap_data, src_pay[0]);
    check("post-reset lock block", lock_rise_block, 64);
    check("post-reset lock word", words_at_lock, 132);

    step(1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
